// File: rtl/seq_alu.sv
// seq_alu: pipelined ALU with a valid/ready handshake and an iterative unsigned multiply/divide unit
module seq_alu #(
    parameter int WIDTH     = 32,
    parameter bit MULDIV_EN = 1'b1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [3:0]       op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] z,
    output logic             zero,
    output logic             ovf,
    output logic             dz,
    output logic             err
);
    localparam int SW = $clog2(WIDTH);
    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
    state_t state_q, state_d;
    logic [SW-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] a_q, b_q, hi_q, hi_d, lo_q, lo_d, z_q, z_d, bx, sum, alu, dif;
    logic [1:0] op_q;
    logic [SW-1:0] sh;
    logic [WIDTH:0] mul_sum, r_sh;
    logic ov_q, ov_d, ovf_q, ovf_d, dz_q, dz_d, err_q, err_d;
    logic accept, md_op, multi, illegal, sub, slt, ovf_c, no_borrow;
    assign in_ready = !reset && state_q == IDLE && (!ov_q || out_ready);
    assign accept   = in_valid && in_ready;
    assign md_op    = op[3] && !op[2];
    assign multi    = MULDIV_EN && md_op;
    assign illegal  = op[3:1] == 3'b111 || (md_op && !MULDIV_EN);
    assign sub      = op == 4'b0110 || op == 4'b0111;
    assign bx       = sub ? ~b : b;
    assign sum      = a + bx + WIDTH'(sub);
    assign sh       = b[SW-1:0];
    // Differing operand signs decide SLT directly, so overflow of a - b cannot corrupt it
    assign slt      = (a[WIDTH-1] != b[WIDTH-1]) ? a[WIDTH-1] : sum[WIDTH-1];
    assign ovf_c    = (op == 4'b0010 || op == 4'b0110) && a[WIDTH-1] == bx[WIDTH-1] && sum[WIDTH-1] != a[WIDTH-1];
    assign mul_sum  = {1'b0, hi_q} + {1'b0, lo_q[0] ? a_q : '0};
    assign r_sh     = {hi_q, lo_q[WIDTH-1]};
    assign no_borrow = r_sh >= {1'b0, b_q};
    assign dif      = r_sh[WIDTH-1:0] - b_q;
    always_comb begin
        alu = '0;
        case (op)
            4'b0000: alu = a & b;
            4'b0001: alu = a | b;
            4'b0010, 4'b0110: alu = sum;
            4'b0111: alu = WIDTH'(slt);
            4'b0011: alu = a ^ b;
            4'b0100: alu = a << sh;
            4'b0101: alu = a >> sh;
            4'b1100: alu = $signed(a) >>> sh;
            4'b1101: alu = WIDTH'(a < b);
            default: alu = '0;
        endcase
    end
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        z_d     = z_q;
        ovf_d   = ovf_q;
        dz_d    = dz_q;
        err_d   = err_q;
        ov_d    = ov_q && !out_ready;
        case (state_q)
            IDLE: if (accept) begin
                if (multi) begin
                    state_d = BUSY;
                    cnt_d   = '0;
                    hi_d    = '0;
                    lo_d    = op[1] ? a : b;
                end else begin
                    ov_d  = 1'b1;
                    z_d   = alu;
                    ovf_d = ovf_c;
                    dz_d  = 1'b0;
                    err_d = illegal;
                end
            end
            BUSY: begin
                cnt_d   = cnt_q + 1'b1;
                hi_d    = op_q[1] ? (no_borrow ? dif : r_sh[WIDTH-1:0]) : mul_sum[WIDTH:1];
                lo_d    = op_q[1] ? {lo_q[WIDTH-2:0], no_borrow} : {mul_sum[0], lo_q[WIDTH-1:1]};
                state_d = cnt_q == SW'(WIDTH - 1) ? DONE : BUSY;
            end
            DONE: begin
                state_d = IDLE;
                ov_d    = 1'b1;
                z_d     = op_q[0] ? hi_q : lo_q;
                ovf_d   = 1'b0;
                dz_d    = op_q[1] && b_q == '0;
                err_d   = 1'b0;
            end
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            ov_q    <= 1'b0;
            z_q     <= '0;
            ovf_q   <= 1'b0;
            dz_q    <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ov_q    <= ov_d;
            z_q     <= z_d;
            ovf_q   <= ovf_d;
            dz_q    <= dz_d;
            err_q   <= err_d;
        end
    end
    always_ff @(posedge clk) begin
        hi_q <= hi_d;
        lo_q <= lo_d;
        if (accept) begin
            a_q  <= a;
            b_q  <= b;
            op_q <= op[1:0];
        end
    end
    assign out_valid = ov_q;
    assign z         = z_q;
    assign zero      = ~|z_q;
    assign ovf       = ovf_q;
    assign dz        = dz_q;
    assign err       = err_q;
endmodule

// File: tb/tb_seq_alu.sv
// tb_seq_alu: directed self-checking bench for seq_alu, with and without the multiply/divide unit
module tb_seq_alu;
    logic clk = 1'b0, reset = 1'b1, in_valid = 1'b0, out_ready = 1'b1;
    logic [31:0] a = '0, b = '0;
    logic [3:0] op = '0;
    logic in_ready, out_valid, zero, ovf, dz, err;
    logic [31:0] z;
    logic c_valid = 1'b0, c_oready = 1'b1;
    logic [31:0] c_a = '0, c_b = '0;
    logic [3:0] c_op = '0;
    logic c_ready, c_ovalid, c_zero, c_ovf, c_dz, c_err;
    logic [31:0] c_z;
    int checks = 0, errors = 0;

    seq_alu #(.WIDTH(32), .MULDIV_EN(1'b1)) u_dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .op(op), .out_valid(out_valid), .out_ready(out_ready),
        .z(z), .zero(zero), .ovf(ovf), .dz(dz), .err(err)
    );
    seq_alu #(.WIDTH(32), .MULDIV_EN(1'b0)) u_nomd (
        .clk(clk), .reset(reset), .in_valid(c_valid), .in_ready(c_ready),
        .a(c_a), .b(c_b), .op(c_op), .out_valid(c_ovalid), .out_ready(c_oready),
        .z(c_z), .zero(c_zero), .ovf(c_ovf), .dz(c_dz), .err(c_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // flags are packed {zero, ovf, dz, err}
    task automatic single(input string tag, input logic [3:0] o, input logic [31:0] x, input logic [31:0] y,
                          input logic [31:0] ez, input logic [3:0] efl);
        @(negedge clk);
        op = o; a = x; b = y; in_valid = 1'b1;
        chk({tag, "_rdy"}, 32'(in_ready), 32'd1);
        @(posedge clk);
        #1 in_valid = 1'b0;
        chk({tag, "_vld"}, 32'(out_valid), 32'd1);
        chk({tag, "_z"}, z, ez);
        chk({tag, "_fl"}, {28'd0, zero, ovf, dz, err}, {28'd0, efl});
    endtask

    task automatic multi(input string tag, input logic [3:0] o, input logic [31:0] x, input logic [31:0] y,
                         input logic [31:0] ez, input logic edz);
        int n;
        int i;
        logic bad;
        @(negedge clk);
        op = o; a = x; b = y; in_valid = 1'b1;
        chk({tag, "_rdy"}, 32'(in_ready), 32'd1);
        @(posedge clk);
        #1 in_valid = 1'b0;
        a = '1; b = '1;
        bad = in_ready | out_valid;
        n = 0;
        i = 0;
        while (n == 0 && i < 40) begin
            @(posedge clk);
            #1 i++;
            if (out_valid) n = i;
            else if (in_ready) bad = 1'b1;
        end
        chk({tag, "_lat"}, 32'(n), 32'd33);
        chk({tag, "_busy"}, 32'(bad), 32'd0);
        chk({tag, "_z"}, z, ez);
        chk({tag, "_fl"}, {28'd0, zero, ovf, dz, err}, {28'd0, (ez == 0), 1'b0, edz, 1'b0});
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    initial begin
        bit seen;
        @(posedge clk);
        @(posedge clk);
        #1;
        chk("rst_rdy", 32'(in_ready), 32'd0);
        chk("rst_vld", 32'(out_valid), 32'd0);
        chk("rst_z", z, 32'd0);
        chk("rst_fl", {28'd0, zero, ovf, dz, err}, 32'b1000);
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1 chk("post_rst_rdy", 32'(in_ready), 32'd1);

        single("add_ovf", 4'b0010, 32'h7FFF_FFFF, 32'd1, 32'h8000_0000, 4'b0100);
        single("sub_zero", 4'b0110, 32'd5, 32'd5, 32'd0, 4'b1000);
        single("sub_ovf", 4'b0110, 32'h8000_0000, 32'd1, 32'h7FFF_FFFF, 4'b0100);
        single("slt", 4'b0111, 32'h8000_0000, 32'd1, 32'd1, 4'b0000);
        single("slt_vf", 4'b0111, 32'h7FFF_FFFF, 32'h8000_0000, 32'd0, 4'b1000);
        single("sltu", 4'b1101, 32'h8000_0000, 32'd1, 32'd0, 4'b1000);
        single("sra", 4'b1100, 32'hF000_0000, 32'd4, 32'hFF00_0000, 4'b0000);
        single("srl", 4'b0101, 32'hF000_0000, 32'd4, 32'h0F00_0000, 4'b0000);
        single("sll", 4'b0100, 32'd1, 32'd31, 32'h8000_0000, 4'b0000);
        single("xor", 4'b0011, 32'h0000_F0F0, 32'h0000_FF00, 32'h0000_0FF0, 4'b0000);
        single("or", 4'b0001, 32'h0000_00F0, 32'h0000_000F, 32'h0000_00FF, 4'b0000);
        single("ill_e", 4'b1110, 32'd5, 32'd3, 32'd0, 4'b1001);
        single("ill_f", 4'b1111, 32'd5, 32'd3, 32'd0, 4'b1001);

        multi("mul", 4'b1000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0);
        multi("mulhu", 4'b1001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 1'b0);
        multi("divu", 4'b1010, 32'd100, 32'd7, 32'd14, 1'b0);
        multi("remu", 4'b1011, 32'd100, 32'd7, 32'd2, 1'b0);
        multi("divu_z", 4'b1010, 32'd9, 32'd0, 32'hFFFF_FFFF, 1'b1);
        multi("remu_z", 4'b1011, 32'd9, 32'd0, 32'd9, 1'b1);

        single("bp_add", 4'b0010, 32'd3, 32'd4, 32'd7, 4'b0000);
        out_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            @(posedge clk);
            #1;
            chk("bp_hold_z", z, 32'd7);
            chk("bp_hold_vld", 32'(out_valid), 32'd1);
            chk("bp_hold_rdy", 32'(in_ready), 32'd0);
        end
        @(negedge clk);
        out_ready = 1'b1;
        single("bp_and", 4'b0000, 32'hFF00_FF00, 32'h0FF0_0FF0, 32'h0F00_0F00, 4'b0000);
        @(posedge clk);
        #1 chk("bp_drain", 32'(out_valid), 32'd0);

        @(negedge clk);
        op = 4'b1010; a = 32'd100; b = 32'd7; in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        repeat (9) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1 chk("abort_rst_rdy", 32'(in_ready), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1 chk("abort_rdy", 32'(in_ready), 32'd1);
        seen = out_valid;
        repeat (40) begin
            @(posedge clk);
            #1 seen |= out_valid;
        end
        chk("abort_novld", 32'(seen), 32'd0);

        @(negedge clk);
        c_op = 4'b1000; c_a = 32'd3; c_b = 32'd4; c_valid = 1'b1;
        chk("nomd_rdy", 32'(c_ready), 32'd1);
        @(posedge clk);
        #1 c_valid = 1'b0;
        chk("nomd_mul_vld", 32'(c_ovalid), 32'd1);
        chk("nomd_mul_z", c_z, 32'd0);
        chk("nomd_mul_err", 32'(c_err), 32'd1);
        @(negedge clk);
        c_op = 4'b1010; c_a = 32'd9; c_b = 32'd0; c_valid = 1'b1;
        @(posedge clk);
        #1 c_valid = 1'b0;
        chk("nomd_div_vld", 32'(c_ovalid), 32'd1);
        chk("nomd_div_fl", {28'd0, c_zero, c_ovf, c_dz, c_err}, 32'b1001);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/seq_alu.md
Name: seq_alu

Overview:
- Parametrised, multi-cycle successor to the CPU's combinational 32-bit ALU.
- Keeps the existing AND/OR/ADD/SUB/SLT encoding and zero flag.
- Adds XOR, shifts, SLTU, overflow and an iterative unsigned multiply/divide unit.
- Sits between the decode/register-read stage and writeback, behind a valid/ready handshake, so the pipeline can stall on long operations.

Parameters:
- WIDTH, 32, datapath width; power of two, >= 8. SW = log2(WIDTH) is the shift-amount width.
- MULDIV_EN, 1, when 0 the multiply/divide ops are illegal and no multi-cycle hardware is built.

Ports:
- clk  in  1  system clock, all state changes on the rising edge
- reset  in  1  synchronous, active-high reset
- in_valid  in  1  operand/op presented
- in_ready  out  1  block can accept this cycle
- a  in  WIDTH  operand A
- b  in  WIDTH  operand B; b[SW-1:0] is the shift amount
- op  in  4  operation select
- out_valid  out  1  result registered and held
- out_ready  in  1  consumer takes the result
- z  out  WIDTH  result
- zero  out  1  z == 0
- ovf  out  1  signed overflow (ADD/SUB only, else 0)
- dz  out  1  divide by zero (DIVU/REMU only, else 0)
- err  out  1  illegal op; z = 0

Behaviour:
- Op encoding:
  - Group 0 (op[3]=0): 0000 AND, 0001 OR, 0010 ADD, 0110 SUB, 0111 SLT signed, 0011 XOR, 0100 SLL, 0101 SRL.
  - Group 1 (op[3]=1): 1000 MUL (low WIDTH bits), 1001 MULHU (high WIDTH bits), 1010 DIVU, 1011 REMU, 1100 SRA, 1101 SLTU.
  - 1110 and 1111 are illegal, as are 1000-1011 when MULDIV_EN = 0.
- Arithmetic rules:
  - SUB computes a + ~b + 1; ADD/SUB wrap modulo 2^WIDTH.
  - ovf = (sign a == sign b') && (sign z != sign a), where b' = b for ADD and ~b for SUB.
  - SLT and SLTU return 1 or 0, zero-extended.
  - SLT must be correct when a - b overflows: use sign a when the operand signs differ, else the sign of the difference.
- Handshake:
  - Accept = in_valid && in_ready.
  - in_ready = (state == IDLE) && (!out_valid || out_ready). This allows back-to-back single-cycle ops at one per clock while the consumer is ready.
  - a, b and op are captured on accept and may change afterwards.
- Latency:
  - Single-cycle ops (all except MUL/MULHU/DIVU/REMU): out_valid is high on the edge after accept.
  - Multi-cycle ops: out_valid is high exactly WIDTH+1 cycles after the accept edge.
  - Single-cycle ops never bypass an active multi-cycle op.
- Output hold:
  - While out_valid && !out_ready, z/zero/ovf/dz/err are stable.
  - out_valid drops on the edge where out_ready=1, unless a new single-cycle op is accepted on that same edge; out_valid then stays 1 with the new result.
- FSM:
  - IDLE: accept a multi-cycle op -> BUSY, count = 0; accept a single-cycle op -> stay in IDLE and load the result registers.
  - BUSY: one iteration per cycle, count++. At count == WIDTH-1 -> DONE.
  - DONE: load the result registers, set out_valid -> IDLE. DONE is entered only when the output register is free, which is guaranteed by in_ready.
- Multiply: shift-add over a 2*WIDTH product register, one bit of b per cycle, LSB first. MUL returns the low half; MULHU returns the high half.
- Divide: restoring division, one quotient bit per cycle, MSB first.
- Divide by zero (b == 0): DIVU returns all ones and REMU returns a. dz = 1, and the result still takes the full WIDTH+1 latency.
- Illegal op: single-cycle; z = 0, zero = 1, err = 1.
- Reset:
  - Forces IDLE, count = 0, out_valid = 0, z = 0, zero = 1, ovf = dz = err = 0.
  - in_ready is 0 during the reset cycle and 1 on the cycle after.
  - Reset mid-BUSY aborts the operation; no result is ever presented for it.
- The accept condition ignores in_valid during reset.

Test Plan:
- WIDTH=32, ADD a=0x7FFFFFFF b=1, out_ready=1 -> next cycle out_valid=1, z=0x80000000, ovf=1, zero=0; SUB a=5 b=5 -> z=0, zero=1, ovf=0.
- SLT a=0x80000000 b=1 -> z=1; SLTU same operands -> z=0; SRA a=0xF0000000 b=4 -> z=0xFF000000; SRL same -> z=0x0F000000.
- MUL a=0xFFFFFFFF b=0xFFFFFFFF -> out_valid exactly 33 cycles after accept, z=0x00000001; MULHU same -> z=0xFFFFFFFE; in_ready=0 throughout BUSY.
- DIVU a=100 b=7 -> z=14; REMU -> z=2; DIVU a=9 b=0 -> z=0xFFFFFFFF, dz=1; REMU a=9 b=0 -> z=9, dz=1.
- Back-pressure: hold out_ready=0 after ADD 3+4 -> z=7 held stable and in_ready=0 for 5 cycles; raise out_ready with a new AND queued on in_valid -> accepted on that edge, next z = AND result, no bubble.
- Reset asserted 10 cycles into a DIVU, op=1110 and MULDIV_EN=0 cases:
  - Reset mid-DIVU -> out_valid never rises for it; in_ready=1 one cycle after reset drops.
  - op=1110 -> err=1, z=0.
  - MULDIV_EN=0 with MUL -> err=1, 1-cycle latency.
